// File: rtl/conv3d_window_gen.sv
// Purpose : raster-order pixel stream -> KERN_L x KERN_H x KERN_W sliding windows ("valid" convolution, no padding).
// Latency : 1 cycle from the accepting edge of the completing pixel to dout/dout_vld.
// Backpressure: none; one pixel per cycle when din_vld=1, and all state holds when din_vld=0.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   din_vld, sof  pixel valid; start-of-frame (sampled only with din_vld) forces the pixel to (0,0)
//   din           one pixel, all KERN_L channels
//   dout_vld      1-cycle pulse per completed window
//   dout          window, dout[l][h][w]; [l][KERN_H-1][KERN_W-1] is the newest pixel
//   eof           pulses with dout_vld on the last window of a frame
//
// Optional build macro CONV3D_WINDOW_STRIDE2_EN: emit only windows whose top-left
// corner lies on even row/column offsets (stride 2).
module conv3d_window_gen #(
  parameter int DIN_WIDTH = 8,
  parameter int KERN_H    = 3,
  parameter int KERN_W    = 3,
  parameter int KERN_L    = 3,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32
) (
  input  logic                                                      clk,
  input  logic                                                      reset_n,
  input  logic                                                      din_vld,
  input  logic                                                      sof,
  input  logic [KERN_L-1:0][DIN_WIDTH-1:0]                          din,
  output logic                                                      dout_vld,
  output logic [KERN_L-1:0][KERN_H-1:0][KERN_W-1:0][DIN_WIDTH-1:0]  dout,
  output logic                                                      eof
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KERN_W - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KERN_H - 1);

  // Position of the completing pixel of the last emitted window in a frame.
`ifdef CONV3D_WINDOW_STRIDE2_EN
  localparam int ROW_EMIT_LAST_I = (KERN_H - 1) + 2 * ((IMG_H - KERN_H) / 2);
  localparam int COL_EMIT_LAST_I = (KERN_W - 1) + 2 * ((IMG_W - KERN_W) / 2);
`else
  localparam int ROW_EMIT_LAST_I = IMG_H - 1;
  localparam int COL_EMIT_LAST_I = IMG_W - 1;
`endif
  localparam logic [RW-1:0] ROW_EMIT_LAST = RW'(ROW_EMIT_LAST_I);
  localparam logic [CW-1:0] COL_EMIT_LAST = CW'(COL_EMIT_LAST_I);

  typedef logic [KERN_L-1:0][DIN_WIDTH-1:0] pix_t;
  typedef logic [KERN_L-1:0][KERN_H-1:0][KERN_W-1:0][DIN_WIDTH-1:0] win_t;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;

  // lb[0] holds the oldest row (r-(KERN_H-1)), lb[KERN_H-2] holds row r-1.
  pix_t lb [0:KERN_H-2][0:IMG_W-1];

  logic [KERN_H-1:0][KERN_L-1:0][DIN_WIDTH-1:0] new_col;
  win_t win_q;
  win_t win_d;
  logic win_ok;
  logic at_last;

  // sof relocates the incoming pixel to (0,0) before any address or gating is derived.
  always_comb begin
    pos_col = sof ? '0 : col_cnt;
    pos_row = sof ? '0 : row_cnt;
  end

  // New column: older rows straight out of the line buffers (read-before-write), newest row from din.
  always_comb begin
    new_col = '0;
    for (int h = 0; h < KERN_H - 1; h++) begin
      new_col[h] = lb[h][pos_col];
    end
    new_col[KERN_H-1] = din;
  end

  // Shift the window one column left and append the new column on the right.
  always_comb begin
    win_d = '0;
    for (int l = 0; l < KERN_L; l++) begin
      for (int h = 0; h < KERN_H; h++) begin
        for (int w = 0; w < KERN_W - 1; w++) begin
          win_d[l][h][w] = win_q[l][h][w+1];
        end
        win_d[l][h][KERN_W-1] = new_col[h][l];
      end
    end
  end

  // Column gating also keeps windows from straddling a row boundary.
  always_comb begin
    win_ok = (pos_row >= ROW_FIRST_WIN) && (pos_col >= COL_FIRST_WIN);
`ifdef CONV3D_WINDOW_STRIDE2_EN
    // Offset (pos - first) is even exactly when the LSBs match.
    win_ok = win_ok && (pos_row[0] == ROW_FIRST_WIN[0]) && (pos_col[0] == COL_FIRST_WIN[0]);
`endif
    at_last = (pos_row == ROW_EMIT_LAST) && (pos_col == COL_EMIT_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      win_q    <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      eof      <= 1'b0;
    end else if (din_vld) begin
      if (pos_col == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_cnt <= pos_col + 1'b1;
        row_cnt <= pos_row;
      end
      win_q    <= win_d;
      dout_vld <= win_ok;
      eof      <= win_ok && at_last;
      // dout only moves on emitted windows so it stays stable between pulses.
      if (win_ok) begin
        dout <= win_d;
      end
    end else begin
      dout_vld <= 1'b0;
      eof      <= 1'b0;
    end
  end

  // Line buffer storage is intentionally not reset; the first KERN_H-1 rows of a frame are gated.
  always_ff @(posedge clk) begin
    if (din_vld) begin
      for (int k = 0; k < KERN_H - 2; k++) begin
        lb[k][pos_col] <= lb[k+1][pos_col];
      end
      lb[KERN_H-2][pos_col] <= din;
    end
  end

endmodule

// File: tb/tb_conv3d_window_gen.sv
module tb_conv3d_window_gen;

  localparam int DW = 8;
  localparam int KH = 3;
  localparam int KW = 3;
  localparam int KL = 2;
  localparam int IW = 5;
  localparam int IH = 4;
  localparam int NPIX = IW * IH;

`ifdef CONV3D_WINDOW_STRIDE2_EN
  localparam int STRIDE  = 2;
  localparam int EXP_WIN = 2;
  localparam int NEWEST [6] = '{12, 14, 0, 0, 0, 0};
`else
  localparam int STRIDE  = 1;
  localparam int EXP_WIN = 6;
  localparam int NEWEST [6] = '{12, 13, 14, 17, 18, 19};
`endif

  typedef logic [KL-1:0][DW-1:0] pix_t;
  typedef logic [KL-1:0][KH-1:0][KW-1:0][DW-1:0] win_t;

  logic clk;
  logic reset_n;
  logic din_vld;
  logic sof;
  pix_t din;
  logic dout_vld;
  win_t dout;
  logic eof;

  conv3d_window_gen #(
    .DIN_WIDTH(DW), .KERN_H(KH), .KERN_W(KW), .KERN_L(KL), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .din_vld(din_vld), .sof(sof), .din(din),
    .dout_vld(dout_vld), .dout(dout), .eof(eof)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model: image array indexed by pixel position ----------------
  pix_t img [IH][IW];
  int   mr, mc;
  int   pr, pc;
  logic mvld, meof;
  win_t mdout;

  assign pr = sof ? 0 : mr;
  assign pc = sof ? 0 : mc;

  function automatic bit is_win(int r, int c);
    return (r >= KH - 1) && (c >= KW - 1) &&
           (((r - (KH - 1)) % STRIDE) == 0) && (((c - (KW - 1)) % STRIDE) == 0);
  endfunction

  // Last window of a frame: no later raster position yields a window.
  function automatic bit is_last(int r, int c);
    if (!is_win(r, c)) return 1'b0;
    for (int p = r * IW + c + 1; p < NPIX; p++) begin
      if (is_win(p / IW, p % IW)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic win_t build_win(int r, int c, pix_t cur);
    win_t wv;
    wv = '0;
    for (int l = 0; l < KL; l++)
      for (int h = 0; h < KH; h++)
        for (int w = 0; w < KW; w++) begin
          if (h == KH - 1 && w == KW - 1) wv[l][h][w] = cur[l];
          else                            wv[l][h][w] = img[r - (KH - 1) + h][c - (KW - 1) + w][l];
        end
    return wv;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mr    <= 0;
      mc    <= 0;
      mvld  <= 1'b0;
      meof  <= 1'b0;
      mdout <= '0;
    end else if (din_vld) begin
      img[pr][pc] <= din;
      mvld <= is_win(pr, pc);
      meof <= is_last(pr, pc);
      if (is_win(pr, pc)) mdout <= build_win(pr, pc, din);
      if (pc == IW - 1) begin
        mc <= 0;
        mr <= (pr == IH - 1) ? 0 : pr + 1;
      end else begin
        mc <= pc + 1;
        mr <= pr;
      end
    end else begin
      mvld <= 1'b0;
      meof <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int   tests;
  int   fails;
  win_t win_log [$];
  bit   eof_log [$];

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: compare DUT to model at the falling edge, then return 2 time units after the rising edge.
  task automatic cycle();
    @(negedge clk);
    chk("cyc_vld",  144'(dout_vld), 144'(mvld));
    chk("cyc_eof",  144'(eof),      144'(meof));
    chk("cyc_dout", 144'(dout),     144'(mdout));
    if (dout_vld) begin
      win_log.push_back(dout);
      eof_log.push_back(eof);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input int idx, input bit s);
    din_vld = 1'b1;
    sof     = s;
    din[1]  = 8'(100 + idx);
    din[0]  = 8'(idx);
    cycle();
    din_vld = 1'b0;
    sof     = 1'b0;
  endtask

  task automatic frame(input bit rnd, input bit sof_first);
    for (int idx = 0; idx < NPIX; idx++) begin
      if (rnd && ($urandom_range(0, 1) == 1)) cycle();
      push(idx, sof_first && (idx == 0));
    end
  endtask

  task automatic check_phase(input string nm, input int base, input int n);
    win_t w;
    chk({nm, "_count"}, 144'(win_log.size() - base), 144'(n));
    for (int i = 0; i < n && base + i < win_log.size(); i++) begin
      w = win_log[base + i];
      chk({nm, "_newest"}, 144'(w[0][KH-1][KW-1]), 144'(NEWEST[i]));
      chk({nm, "_eof"},    144'(eof_log[base + i]), 144'(i == n - 1));
    end
  endtask

  initial begin
    int   b;
    win_t w;
    tests   = 0;
    fails   = 0;
    clk     = 1'b0;
    reset_n = 1'b0;
    din_vld = 1'b0;
    sof     = 1'b0;
    din     = '0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Reset state and idle input.
    chk("reset_dout", 144'(dout), 144'(0));
    chk("reset_vld",  144'(dout_vld), 144'(0));
    idle(20);
    chk("idle_no_windows", 144'(win_log.size()), 144'(0));

    // Continuous frame.
    b = win_log.size();
    frame(1'b0, 1'b0);
    idle(3);
    check_phase("cont", b, EXP_WIN);
    if (win_log.size() > b) begin
      w = win_log[b];
      chk("first_000", 144'(w[0][0][0]), 144'(0));
      chk("first_022", 144'(w[0][2][2]), 144'(12));
      chk("first_111", 144'(w[1][1][1]), 144'(106));
    end else begin
      chk("first_present", 144'(0), 144'(1));
    end

    // Same frame with random bubbles.
    b = win_log.size();
    frame(1'b1, 1'b0);
    idle(3);
    check_phase("bubbles", b, EXP_WIN);

    // Two back-to-back frames.
    b = win_log.size();
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    idle(3);
    chk("b2b_count", 144'(win_log.size() - b), 144'(2 * EXP_WIN));
    if (win_log.size() > b + EXP_WIN) begin
      w = win_log[b + EXP_WIN];
      chk("b2b_second_000", 144'(w[0][0][0]), 144'(0));
      chk("b2b_second_022", 144'(w[0][2][2]), 144'(12));
    end

    // Partial frame, then resync with sof.
    for (int idx = 0; idx < 7; idx++) push(idx, 1'b0);
    b = win_log.size();
    frame(1'b0, 1'b1);
    idle(3);
    check_phase("sof", b, EXP_WIN);

    // Reset pulsed mid-frame while a window is being presented.
    for (int idx = 0; idx < 15; idx++) push(idx, 1'b0);
    chk("pre_rst_vld", 144'(dout_vld), 144'(1));
    reset_n = 1'b0;
    #1;
    chk("rst_async_vld",  144'(dout_vld), 144'(0));
    chk("rst_async_eof",  144'(eof), 144'(0));
    chk("rst_async_dout", 144'(dout), 144'(0));
    idle(2);
    reset_n = 1'b1;
    b = win_log.size();
    frame(1'b0, 1'b0);
    idle(3);
    check_phase("post_rst", b, EXP_WIN);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
